int_to_fp: RTL and testbench

Sequential converter from a 32-bit two's-complement integer to the team's 32-bit float format: sign bit 31, 9-bit exponent in bits 30:22, 22-bit mantissa in bits 21:0 with a hidden leading 1. Bias is 255, and zero is all-zero in bits 30:0. It is the producer end of the FPU datapath: integer sources are encoded here, and the results feed the `fpu` adder operands. Normalization is iterative (one bit per cycle) and followed by a single round-to-nearest-even step.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fp_round_rne.sv | 33 +++
 rtl/int_to_fp.sv | 114 +++++++++++
 tb/tb_int_to_fp.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU datapath: float format, bias and status codes.
package fpu_pkg;

   localparam int EXP_W = 9;
   localparam int MAN_W = 22;
   localparam int BIAS  = 255;

   // status_out encoding: {EXACT, OVERFLOW, UNDERFLOW, INEXACT}
   localparam logic [3:0] ST_EXACT   = 4'b1000;
   localparam logic [3:0] ST_INEXACT = 4'b0001;
   localparam logic [3:0] ST_OVF     = 4'b0100;
   localparam logic [3:0] ST_UNF     = 4'b0010;

   // 32-bit float word: sign, biased exponent, mantissa with hidden leading 1
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized magnitude (hidden bit stripped) to
// MAN_W mantissa bits, carrying into the exponent when the mantissa overflows.
module fp_round_rne
   import fpu_pkg::*;
(
   input  logic [30:0]      mag,
   input  logic [EXP_W-1:0] exp_pre,
   output logic [MAN_W-1:0] man,
   output logic [EXP_W-1:0] exp_rnd,
   output logic             inexact
);

   // Returns {exponent, mantissa, inexact}
   function automatic logic [EXP_W+MAN_W:0] round_rne(input logic [30:0]      m,
                                                       input logic [EXP_W-1:0] e);
      logic             guard;
      logic             sticky;
      logic             up;
      logic [MAN_W:0]   sum;
      logic [EXP_W-1:0] e_r;
      guard  = m[8];
      sticky = |m[7:0];
      // ties go up only when the kept LSB is odd
      up     = guard & (sticky | m[9]);
      sum    = {1'b0, m[30:9]} + {{MAN_W{1'b0}}, up};
      // on carry-out the low MAN_W bits of sum are already zero
      e_r    = sum[MAN_W] ? e + 1'b1 : e;
      return {e_r, sum[MAN_W-1:0], guard | sticky};
   endfunction

   assign {exp_rnd, man, inexact} = round_rne(mag, exp_pre);

endmodule

// File: rtl/int_to_fp.sv
// Signed 32-bit integer to float converter: absolute value, one-bit-per-cycle
// normalization, then a single round-to-nearest-even step.
module int_to_fp
   import fpu_pkg::*;
#(
   parameter int BIAS = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start_in,
   input  logic signed [31:0] int_in,
   output logic               busy_out,
   output logic               done_out,
   output logic [31:0]        data_out,
   output logic [3:0]         status_out
);

   typedef enum logic [1:0] {S_IDLE, S_ABS, S_NORM, S_ROUND} state_t;

   // exponent of a magnitude whose leading one sits at bit 31
   localparam logic [EXP_W-1:0] EXP_START = EXP_W'(BIAS + 31);

   state_t             state;
   state_t             state_nxt;
   logic signed [31:0] int_lat;
   logic [31:0]        abs_mag;
   logic [31:0]        mag;
   logic [EXP_W-1:0]   exp_cur;
   logic               sign;
   logic [MAN_W-1:0]   man_rnd;
   logic [EXP_W-1:0]   exp_rnd;
   logic               inexact;
   fp_t                rnd_fp;
   logic [31:0]        data_nxt;
   logic [3:0]         status_nxt;
   logic               done_nxt;

   // -2^31 negates onto itself, which read as unsigned is the wanted 0x80000000
   assign abs_mag  = int_lat[31] ? $unsigned(-int_lat) : $unsigned(int_lat);
   assign busy_out = (state != S_IDLE);

   fp_round_rne u_round (
      .mag     (mag[30:0]),
      .exp_pre (exp_cur),
      .man     (man_rnd),
      .exp_rnd (exp_rnd),
      .inexact (inexact)
   );

   // Datapath registers: operand latch, magnitude shifter and exponent counter
   always_ff @(posedge clock) begin
      case (state)
         S_IDLE: if (start_in) int_lat <= int_in;
         S_ABS: begin
            sign    <= int_lat[31];
            mag     <= abs_mag;
            exp_cur <= EXP_START;
         end
         S_NORM: if (!mag[31]) begin
            mag     <= mag << 1;
            exp_cur <= exp_cur - 1'b1;
         end
         default: ;
      endcase
   end

   // State and result registers; reset aborts any conversion in flight
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         data_out   <= '0;
         status_out <= ST_EXACT;
         done_out   <= 1'b0;
      end else begin
         state      <= state_nxt;
         data_out   <= data_nxt;
         status_out <= status_nxt;
         done_out   <= done_nxt;
      end
   end

   // Next-state and next-result decode
   always_comb begin
      state_nxt   = state;
      data_nxt    = data_out;
      status_nxt  = status_out;
      done_nxt    = 1'b0;
      rnd_fp.sign = sign;
      rnd_fp.exp  = exp_rnd;
      rnd_fp.man  = man_rnd;
      case (state)
         S_IDLE: if (start_in) state_nxt = S_ABS;
         S_ABS: begin
            if (abs_mag == 32'd0) begin
               data_nxt   = '0;
               status_nxt = ST_EXACT;
               done_nxt   = 1'b1;
               state_nxt  = S_IDLE;
            end else begin
               state_nxt  = S_NORM;
            end
         end
         S_NORM: if (mag[31]) state_nxt = S_ROUND;
         S_ROUND: begin
            data_nxt   = rnd_fp;
            status_nxt = inexact ? ST_INEXACT : ST_EXACT;
            done_nxt   = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_int_to_fp.sv
// Scoreboard bench for int_to_fp: stimulus pushes expected results, a monitor
// pops and compares data, status and latency on every done_out pulse.
module tb_int_to_fp;

   logic               clock    = 1'b0;
   logic               reset    = 1'b0;
   logic               start_in = 1'b0;
   logic signed [31:0] int_in   = '0;
   logic               busy_out;
   logic               done_out;
   logic [31:0]        data_out;
   logic [3:0]         status_out;

   typedef struct {
      int          tag;
      logic [31:0] data;
      logic [3:0]  status;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   int_to_fp #(.BIAS(255)) dut (
      .clock      (clock),
      .reset      (reset),
      .start_in   (start_in),
      .int_in     (int_in),
      .busy_out   (busy_out),
      .done_out   (done_out),
      .data_out   (data_out),
      .status_out (status_out)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every done_out pulse must match the oldest outstanding request
   always @(negedge clock) begin
      exp_t e;
      if (reset && done_out) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done_out=1 data 0x%08h, expected no result", data_out);
         end else begin
            e = sb.pop_front();
            check($sformatf("data[%0d]", e.tag), data_out, e.data);
            check($sformatf("status[%0d]", e.tag), {28'd0, status_out}, {28'd0, e.status});
            check($sformatf("latency[%0d]", e.tag), 32'(cyc - e.start_cyc), 32'(e.lat));
         end
      end
   end

   // Wait for idle, present an operand for one sampling edge, record expectation
   task automatic issue(input int tag, input logic [31:0] v, input logic [31:0] d,
                        input logic [3:0] s, input int lat, input bit hold);
      int n;
      n = 0;
      @(negedge clock);
      while (busy_out && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (busy_out) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout[%0d]: busy_out still 1 after %0d cycles, expected 0", tag, n);
      end
      int_in   = v;
      start_in = 1'b1;
      @(posedge clock);
      #1;
      sb.push_back('{tag: tag, data: d, status: s, lat: lat, start_cyc: cyc});
      if (!hold) start_in = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time exhausted, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // reset values
      repeat (3) @(negedge clock);
      check("rst_data", data_out, 32'h0000_0000);
      check("rst_status", {28'd0, status_out}, 32'h8);
      check("rst_busy", {31'd0, busy_out}, 32'd0);
      check("rst_done", {31'd0, done_out}, 32'd0);
      reset = 1'b1;

      // basic conversions and rounding cases
      issue(0, 32'h0000_0001, 32'h3FC0_0000, 4'b1000, 34, 1'b0);
      issue(1, 32'hFFFF_FFFA, 32'hC060_0000, 4'b1000, 32, 1'b0);
      issue(2, 32'h8000_0000, 32'hC780_0000, 4'b1000, 3, 1'b0);
      issue(3, 32'h0000_0000, 32'h0000_0000, 4'b1000, 1, 1'b0);
      issue(4, 32'h7FFF_FFFF, 32'h4780_0000, 4'b0001, 4, 1'b0);
      issue(5, 32'h0080_0001, 32'h4580_0000, 4'b0001, 11, 1'b0);
      issue(6, 32'h0080_0003, 32'h4580_0002, 4'b0001, 11, 1'b0);
      issue(7, 32'h00FF_FFFF, 32'h45C0_0000, 4'b0001, 11, 1'b0);
      issue(8, 32'h0000_0002, 32'h4000_0000, 4'b1000, 33, 1'b0);

      // start pulse while busy must be ignored
      issue(9, 32'h0000_0003, 32'h4020_0000, 4'b1000, 33, 1'b0);
      repeat (4) @(negedge clock);
      int_in   = 32'sd5;
      start_in = 1'b1;
      @(negedge clock);
      start_in = 1'b0;

      // start held high: back-to-back results
      issue(10, 32'h8000_0000, 32'hC780_0000, 4'b1000, 3, 1'b1);
      issue(11, 32'h0000_0000, 32'h0000_0000, 4'b1000, 1, 1'b1);
      issue(12, 32'hFFFF_FFFA, 32'hC060_0000, 4'b1000, 32, 1'b0);

      // reset in the middle of normalization
      issue(13, 32'h0000_0001, 32'h3FC0_0000, 4'b1000, 34, 1'b0);
      repeat (10) @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort_data", data_out, 32'h0000_0000);
      check("abort_status", {28'd0, status_out}, 32'h8);
      check("abort_busy", {31'd0, busy_out}, 32'd0);
      check("abort_done", {31'd0, done_out}, 32'd0);
      sb.delete();
      @(negedge clock);
      reset = 1'b1;
      issue(14, 32'h0000_0005, 32'h4050_0000, 4'b1000, 32, 1'b0);

      // drain outstanding results
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
      repeat (5) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
